pwm_chan_scheduler: RTL and testbench

Sequencer that fires the pattern PWM/DAC channels one after another in ascending channel order, with a programmable idle gap between them. It sits between the UART register mapper, which issues a command after each decoded packet, and the per-channel pattern generators, which it drives through one-cycle enable pulses. It tracks each channel's busy/valid handshake and reports completion, abort and per-channel errors back to the mapper and the UART TX status path.

---
 rtl/pwm_chan_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_pwm_chan_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_chan_scheduler.sv
// pwm_chan_scheduler
//   Fires the selected PWM/DAC pattern channels one at a time in ascending
//   channel order, with a programmable idle gap between channels. Each
//   channel is started with a one-cycle pwm_en pulse. Its busy/valid
//   handshake is then tracked until the channel completes.
//
//   Optional feature macro: PWM_SCHED_TIMEOUT_EN adds a WAIT_VALID watchdog
//   of _TIMEOUT_WIDTH bits. Without it, WAIT_VALID waits indefinitely.
//
// Ports
//   clk_50M      system clock, rising edge
//   rst          synchronous active-high reset
//   cmd_valid    command strobe, accepted when cmd_ready is high
//   cmd_ch_mask  channels to run (bit i = channel i)
//   cmd_gap      idle cycles between consecutive channels
//   cmd_ready    high only while idle
//   abort        synchronous abort of the running sequence
//   pwm_en       one-hot, one-cycle start pulse per channel
//   pwm_busy     channel busy flags
//   pwm_valid    channel end-of-pattern pulses
//   cur_ch       index of the active channel
//   sched_busy   high while a sequence is in progress
//   sched_done   one-cycle pulse on normal completion
//   err_ch       sticky per-channel error flags, cleared on accept
module pwm_chan_scheduler #(
  parameter int unsigned _NUM_CHANNELS  = 4,
  parameter int unsigned _GAP_WIDTH     = 16,
  parameter int unsigned _TIMEOUT_WIDTH = 24,
  localparam int unsigned CH_W = (_NUM_CHANNELS > 1) ? $clog2(_NUM_CHANNELS) : 1
) (
  input  logic                     clk_50M,
  input  logic                     rst,
  input  logic                     cmd_valid,
  input  logic [_NUM_CHANNELS-1:0] cmd_ch_mask,
  input  logic [_GAP_WIDTH-1:0]    cmd_gap,
  output logic                     cmd_ready,
  input  logic                     abort,
  output logic [_NUM_CHANNELS-1:0] pwm_en,
  input  logic [_NUM_CHANNELS-1:0] pwm_busy,
  input  logic [_NUM_CHANNELS-1:0] pwm_valid,
  output logic [CH_W-1:0]          cur_ch,
  output logic                     sched_busy,
  output logic                     sched_done,
  output logic [_NUM_CHANNELS-1:0] err_ch
);

  typedef enum logic [2:0] {
    IDLE, PICK, FIRE, WAIT_BUSY, WAIT_VALID, GAP, DONE
  } state_t;

  state_t                   state, state_n;
  logic [_NUM_CHANNELS-1:0] pend, pend_n, err_n, en_n;
  logic [CH_W-1:0]          cur_n, lowest;
  logic [_GAP_WIDTH-1:0]    gap_q, gap_q_n, gap_cnt, gap_cnt_n;
  logic [3:0]               wb_cnt, wb_cnt_n;
  logic                     ch_complete, sel_busy, sel_valid;
`ifdef PWM_SCHED_TIMEOUT_EN
  logic [_TIMEOUT_WIDTH-1:0] wv_cnt, wv_cnt_n;
`else
  // Watchdog width only matters when the watchdog is built.
  if (_TIMEOUT_WIDTH == 0) begin : g_no_watchdog
  end
`endif

  assign sel_busy  = pwm_busy[cur_ch];
  assign sel_valid = pwm_valid[cur_ch];

  always_comb begin
    lowest = '0;
    for (int unsigned i = _NUM_CHANNELS; i > 0; i--) begin
      if (pend[i-1]) lowest = CH_W'(i - 1);
    end
  end

  always_comb begin
    state_n     = state;
    pend_n      = pend;
    cur_n       = cur_ch;
    err_n       = err_ch;
    gap_q_n     = gap_q;
    gap_cnt_n   = gap_cnt;
    wb_cnt_n    = wb_cnt;
    ch_complete = 1'b0;
    en_n        = '0;
`ifdef PWM_SCHED_TIMEOUT_EN
    wv_cnt_n    = wv_cnt;
`endif

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          pend_n  = cmd_ch_mask;
          gap_q_n = cmd_gap;
          err_n   = '0;
          state_n = PICK;
        end
      end
      PICK: begin
        if (pend == '0) begin
          state_n = DONE;
        end else begin
          cur_n          = lowest;
          pend_n[lowest] = 1'b0;
          state_n        = FIRE;
        end
      end
      FIRE: begin
        wb_cnt_n = '0;
        state_n  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (sel_valid) begin
          ch_complete = 1'b1;
        end else if (sel_busy) begin
          state_n = WAIT_VALID;
`ifdef PWM_SCHED_TIMEOUT_EN
          wv_cnt_n = _TIMEOUT_WIDTH'(1);
`endif
        end else if (wb_cnt == 4'd15) begin
          // 16th cycle in WAIT_BUSY with no response from the channel.
          err_n[cur_ch] = 1'b1;
          ch_complete   = 1'b1;
        end else begin
          wb_cnt_n = wb_cnt + 4'd1;
        end
      end
      WAIT_VALID: begin
        if (sel_valid) begin
          ch_complete = 1'b1;
        end
`ifdef PWM_SCHED_TIMEOUT_EN
        // Counter holds the 1-based cycle number within WAIT_VALID.
        else if (wv_cnt == '1) begin
          err_n[cur_ch] = 1'b1;
          ch_complete   = 1'b1;
        end else begin
          wv_cnt_n = wv_cnt + 1'b1;
        end
`endif
      end
      GAP: begin
        // Counter starts at 1, so gap_q idle cycles elapse before PICK.
        if (gap_cnt == gap_q) state_n = PICK;
        else gap_cnt_n = gap_cnt + 1'b1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (ch_complete) begin
      if (pend == '0) begin
        state_n = DONE;
      end else if (gap_q == '0) begin
        state_n = PICK;
      end else begin
        state_n   = GAP;
        gap_cnt_n = _GAP_WIDTH'(1);
      end
    end

    if (abort && state != IDLE) begin
      state_n = IDLE;
      pend_n  = '0;
    end

    // Outputs are registered from the next state, so an abort in PICK
    // suppresses the pulse that FIRE would otherwise present.
    if (state_n == FIRE) en_n[cur_n] = 1'b1;
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state      <= IDLE;
      pend       <= '0;
      gap_q      <= '0;
      gap_cnt    <= '0;
      wb_cnt     <= '0;
      cur_ch     <= '0;
      err_ch     <= '0;
      pwm_en     <= '0;
      cmd_ready  <= 1'b1;
      sched_busy <= 1'b0;
      sched_done <= 1'b0;
`ifdef PWM_SCHED_TIMEOUT_EN
      wv_cnt     <= '0;
`endif
    end else begin
      state      <= state_n;
      pend       <= pend_n;
      gap_q      <= gap_q_n;
      gap_cnt    <= gap_cnt_n;
      wb_cnt     <= wb_cnt_n;
      cur_ch     <= cur_n;
      err_ch     <= err_n;
      pwm_en     <= en_n;
      cmd_ready  <= (state_n == IDLE);
      sched_busy <= (state_n != IDLE);
      sched_done <= (state_n == DONE);
`ifdef PWM_SCHED_TIMEOUT_EN
      wv_cnt     <= wv_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_pwm_chan_scheduler.sv
// Bench for pwm_chan_scheduler: hand-computed vector table, hand-written
// abort/reset/no-watchdog sequences, and randomized commands checked against
// an event-timing model derived from the scheduler's rules.
module tb_pwm_chan_scheduler;
  localparam int N = 4;
  localparam int HMAX = 100000;

  logic       clk_50M = 1'b0;
  logic       rst, cmd_valid, abort;
  logic [3:0] cmd_ch_mask, pwm_en, pwm_busy, pwm_valid, err_ch;
  logic [15:0] cmd_gap;
  logic       cmd_ready, sched_busy, sched_done;
  logic [1:0] cur_ch;

  pwm_chan_scheduler #(._NUM_CHANNELS(4), ._GAP_WIDTH(16), ._TIMEOUT_WIDTH(24)) dut (
    .clk_50M(clk_50M), .rst(rst), .cmd_valid(cmd_valid), .cmd_ch_mask(cmd_ch_mask),
    .cmd_gap(cmd_gap), .cmd_ready(cmd_ready), .abort(abort), .pwm_en(pwm_en),
    .pwm_busy(pwm_busy), .pwm_valid(pwm_valid), .cur_ch(cur_ch),
    .sched_busy(sched_busy), .sched_done(sched_done), .err_ch(err_ch)
  );

  always #10 clk_50M = ~clk_50M;

  int cyc = 0;
  always @(posedge clk_50M) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // channel behaviour: busy from fire+bd until fire+vd, valid pulse at fire+vd
  logic [3:0] run_mask;
  bit         noise, spam;
  int ch_bd[N], ch_vd[N], fire_cyc[N], en_cnt[N], exp_fire[N];
  int done_cnt, done_cyc, multi_en, A, exp_done;
  logic [3:0] exp_err;
  bit ready_h[HMAX];
  bit busy_h[HMAX];

  typedef struct {
    logic [3:0] mask;
    int         gap;
    int         bd[N];
    int         vd[N];
    logic [3:0] err;
    int         done_off;
  } vec_t;
  vec_t vecs[$];

  function automatic void add_vec(logic [3:0] m, int g, int b0, int b1, int b2, int b3,
                                  int v0, int v1, int v2, int v3, logic [3:0] e, int d);
    vec_t v;
    v.mask = m; v.gap = g;
    v.bd[0] = b0; v.bd[1] = b1; v.bd[2] = b2; v.bd[3] = b3;
    v.vd[0] = v0; v.vd[1] = v1; v.vd[2] = v2; v.vd[3] = v3;
    v.err = e; v.done_off = d;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic clear_run();
    for (int i = 0; i < N; i++) begin
      fire_cyc[i] = -1;
      en_cnt[i]   = 0;
    end
    done_cnt = 0; done_cyc = -1; multi_en = 0;
  endtask

  // One clock cycle: sample outputs at the falling edge, then drive inputs.
  task automatic tick();
    @(negedge clk_50M);
    if (cyc < HMAX) begin
      ready_h[cyc] = cmd_ready;
      busy_h[cyc]  = sched_busy;
    end
    if ($countones(pwm_en) > 1) multi_en++;
    for (int i = 0; i < N; i++) begin
      if (pwm_en[i]) begin
        en_cnt[i]++;
        fire_cyc[i] = cyc;
      end
    end
    if (sched_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    for (int i = 0; i < N; i++) begin
      if (run_mask[i]) begin
        pwm_busy[i]  = (fire_cyc[i] >= 0) && (cyc >= fire_cyc[i] + ch_bd[i]) &&
                       (cyc < fire_cyc[i] + ch_vd[i]);
        pwm_valid[i] = (fire_cyc[i] >= 0) && (cyc == fire_cyc[i] + ch_vd[i]);
      end else if (noise) begin
        pwm_busy[i]  = 1'($urandom_range(0, 1));
        pwm_valid[i] = 1'($urandom_range(0, 1));
      end else begin
        pwm_busy[i]  = 1'b0;
        pwm_valid[i] = 1'b0;
      end
    end
    cmd_valid = spam && (cyc >= A + 1) && (cyc <= exp_done) && ($urandom_range(0, 2) == 0);
    if (cmd_valid) begin
      cmd_ch_mask = 4'($urandom);
      cmd_gap     = 16'($urandom_range(0, 3));
    end
  endtask

  // Event timing from the scheduler rules: first fire at A+2, a channel
  // completes on its valid (or after 16 silent cycles, flagged as error),
  // next fire at V+gap+2, done at V+1 (A+2 for an empty mask).
  task automatic predict(input logic [3:0] mask, input int gap);
    int t, v;
    t = A + 2; v = A; exp_err = '0;
    for (int i = 0; i < N; i++) begin
      exp_fire[i] = -1;
      if (mask[i]) begin
        exp_fire[i] = t;
        if (ch_vd[i] <= 16 || (ch_bd[i] <= 16 && ch_bd[i] < ch_vd[i])) begin
          v = t + ch_vd[i];
        end else begin
          v = t + 16;
          exp_err[i] = 1'b1;
        end
        t = v + gap + 2;
      end
    end
    exp_done = (mask == '0) ? A + 2 : v + 1;
  endtask

  task automatic run_cmd(input logic [3:0] mask, input int gap, input bit do_spam,
                         input bit do_noise);
    run_mask = mask; noise = do_noise; spam = 1'b0;
    clear_run();
    tick();
    cmd_valid = 1'b1; cmd_ch_mask = mask; cmd_gap = 16'(gap); A = cyc;
    predict(mask, gap);
    spam = do_spam;
    tick();
    while (done_cnt == 0 && cyc < exp_done + 20) tick();
    repeat (40) tick();
    spam = 1'b0; noise = 1'b0;
    check("ready_at_accept", ready_h[A], 1);
    check("busy_a1", busy_h[A+1], 1);
    check("ready_a1", ready_h[A+1], 0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("en_count_ch%0d", i), en_cnt[i], mask[i] ? 1 : 0);
      if (mask[i]) check($sformatf("en_cycle_ch%0d", i), fire_cyc[i] - A, exp_fire[i] - A);
    end
    check("en_onehot", multi_en, 0);
    check("done_count", done_cnt, 1);
    check("done_cycle", done_cyc - A, exp_done - A);
    check("busy_in_done", busy_h[exp_done], 1);
    check("ready_after_done", ready_h[exp_done+1], 1);
    check("busy_after_done", busy_h[exp_done+1], 0);
    check("err_ch", err_ch, exp_err);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_ch_mask = '0; cmd_gap = '0; abort = 1'b0;
    pwm_busy = '0; pwm_valid = '0; run_mask = '0; noise = 1'b0; spam = 1'b0;
    A = 0; exp_done = 0;
    clear_run();

    //        mask    gap  bd0   bd1   bd2   bd3   vd0   vd1   vd2   vd3   err     done
    add_vec(4'b0101, 10,   1,    1,    1,    1,    51,   51,   51,   51,   4'b0000, 117);
    add_vec(4'b0000, 5,    1,    1,    1,    1,    5,    5,    5,    5,    4'b0000, 2);
    add_vec(4'b1111, 0,    1000, 9999, 1,    2,    3,    9999, 5,    4,    4'b0010, 37);
    add_vec(4'b1000, 3,    1,    1,    1,    1000, 5,    5,    5,    16,   4'b0000, 19);
    add_vec(4'b0010, 0,    1,    16,   1,    1,    5,    20,   5,    5,    4'b0000, 23);
    add_vec(4'b0011, 1,    17,   1,    1,    1,    30,   5,    5,    5,    4'b0001, 27);
    add_vec(4'b0011, 300,  1000, 1000, 1,    1,    1,    1,    5,    5,    4'b0000, 307);
    add_vec(4'b0001, 0,    1,    1,    1,    1,    2,    5,    5,    5,    4'b0000, 5);

    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_sched_busy", sched_busy, 0);
    check("rst_sched_done", sched_done, 0);
    check("rst_pwm_en", pwm_en, 0);
    check("rst_cur_ch", cur_ch, 0);
    check("rst_err_ch", err_ch, 0);
    rst = 1'b0;
    tick();

    abort = 1'b1; tick(); abort = 1'b0; tick();
    check("abort_idle_ready", cmd_ready, 1);
    check("abort_idle_busy", sched_busy, 0);

    foreach (vecs[k]) begin
      for (int i = 0; i < N; i++) begin
        ch_bd[i] = vecs[k].bd[i];
        ch_vd[i] = vecs[k].vd[i];
      end
      run_cmd(vecs[k].mask, vecs[k].gap, 1'b0, 1'b0);
      check($sformatf("vec%0d_done_off", k), done_cyc - A, vecs[k].done_off);
      check($sformatf("vec%0d_err", k), err_ch, vecs[k].err);
    end

    // abort while channel 1 waits for valid
    ch_bd = '{1, 1, 1, 1}; ch_vd = '{5, 100, 5, 5};
    run_mask = 4'b0111; clear_run(); exp_done = 0;
    tick();
    cmd_valid = 1'b1; cmd_ch_mask = 4'b0111; cmd_gap = 16'd2; A = cyc; exp_done = A;
    tick();
    while (cyc < A + 20) tick();
    check("abort_pre_busy", sched_busy, 1);
    check("abort_pre_cur_ch", cur_ch, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_ready", cmd_ready, 1);
    check("abort_busy", sched_busy, 0);
    repeat (100) tick();
    check("abort_ch1_fire", fire_cyc[1] - A, 11);
    check("abort_ch2_never", en_cnt[2], 0);
    check("abort_no_done", done_cnt, 0);
    check("abort_err_kept", err_ch, 0);
    check("abort_ready_later", cmd_ready, 1);

    // second command while busy, then reset during the gap
    ch_bd = '{1, 9999, 1, 1}; ch_vd = '{5, 9999, 5, 5};
    run_mask = 4'b0110; clear_run();
    tick();
    cmd_valid = 1'b1; cmd_ch_mask = 4'b0110; cmd_gap = 16'd30; A = cyc; exp_done = A + 24;
    spam = 1'b1;
    tick();
    while (cyc < A + 25) tick();
    spam = 1'b0;
    check("gap_err_before_rst", err_ch, 4'b0010);
    check("gap_cur_ch_before_rst", cur_ch, 1);
    check("gap_busy_before_rst", sched_busy, 1);
    rst = 1'b1; tick();
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_busy", sched_busy, 0);
    check("midrst_pwm_en", pwm_en, 0);
    check("midrst_cur_ch", cur_ch, 0);
    check("midrst_done", sched_done, 0);
    check("midrst_err_ch", err_ch, 0);
    rst = 1'b0;
    repeat (80) tick();
    check("midrst_ch1_once", en_cnt[1], 1);
    check("midrst_ch2_never", en_cnt[2], 0);
    check("midrst_spam_ignored", en_cnt[0] + en_cnt[3], 0);
    check("midrst_no_done", done_cnt, 0);

`ifndef PWM_SCHED_TIMEOUT_EN
    // without the watchdog a busy-but-silent channel holds the scheduler
    ch_bd = '{1, 1, 1, 1}; ch_vd = '{90000, 5, 5, 5};
    run_mask = 4'b0001; clear_run();
    tick();
    cmd_valid = 1'b1; cmd_ch_mask = 4'b0001; cmd_gap = 16'd0; A = cyc; exp_done = A;
    tick();
    repeat (400) tick();
    check("nowd_still_busy", sched_busy, 1);
    check("nowd_no_done", done_cnt, 0);
    check("nowd_no_err", err_ch, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("nowd_abort_ready", cmd_ready, 1);
    run_mask = '0;
    tick();
`endif

    // randomized commands with spam on cmd_valid and noise on unused channels
    for (int r = 0; r < 25; r++) begin
      logic [3:0] m;
      int g;
      m = 4'($urandom);
      g = ($urandom_range(0, 4) == 0) ? 40 : $urandom_range(0, 6);
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 5))
          0, 1: begin ch_bd[i] = 1000; ch_vd[i] = $urandom_range(1, 16); end
          2, 3: begin ch_bd[i] = $urandom_range(1, 16); ch_vd[i] = ch_bd[i] + $urandom_range(1, 30); end
          4: begin ch_bd[i] = 90000; ch_vd[i] = 90000; end
          default: begin ch_bd[i] = $urandom_range(17, 20); ch_vd[i] = ch_bd[i] + $urandom_range(1, 10); end
        endcase
      end
      run_cmd(m, g, 1'b1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
